// File: rtl/pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// pipe_reg_skid : registered valid/ready stage with one-entry skid buffer.
// Optional stall counter: define PIPE_REG_SKID_STALL_CNT_EN.  Rev 1.0
// ============================================================================
module pipe_reg_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush
`ifdef PIPE_REG_SKID_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // State bits are {in_ready, out_valid} so both handshake outputs come straight from flops.
  localparam logic [1:0] EMPTY = 2'b10;
  localparam logic [1:0] ONE   = 2'b11;
  localparam logic [1:0] TWO   = 2'b01;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             deliver;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !deliver)      state_nxt = TWO;
        else if (!accept && deliver) state_nxt = EMPTY;
      end
      TWO:     if (deliver) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_comb begin
    in_ready       = state[1];
    out_valid      = state[0];
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: load_main = accept;
      ONE: begin
        load_main = accept && deliver;
        load_skid = accept && !deliver;
      end
      TWO: begin
        load_main      = deliver;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
    // Flush only clears occupancy; data registers keep their contents.
    if (flush) begin
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign out_data = main_q;

`ifdef PIPE_REG_SKID_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire
